// File: rtl/game_mode_select_pkg.sv
// Shared game-mode definitions used by the mode controller and the VGA control block.
// No logic and no latency.
// No handshakes: types, constants and one pure helper function only.
package game_pkg;

    // Mode code driven to the VGA enable FSM
    typedef enum logic [1:0] {
        MODE_MENU     = 2'd0,
        MODE_REACTION = 2'd1,
        MODE_CHIMP    = 2'd2
    } game_mode_t;

    // Menu-navigation controller states
    typedef enum logic [1:0] {
        MENU  = 2'd0,
        ENTER = 2'd1,
        PLAY  = 2'd2,
        EXIT  = 2'd3
    } fsm_state_t;

    // Number of selectable games; the menu cursor runs 1..NUM_GAMES
    localparam int NUM_GAMES = 2;

    // Map a menu cursor to the mode it starts. Unknown entries fall back to the
    // menu, so the mode code can never be 3.
    function automatic game_mode_t cursor_to_mode(input logic [1:0] cursor);
        game_mode_t mode;
        case (cursor)
            2'd1:    mode = MODE_REACTION;
            2'd2:    mode = MODE_CHIMP;
            default: mode = MODE_MENU;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/game_mode_select_if.sv
// Button, game-done and mode-output bundle of the game mode controller.
// No logic and no latency.
// No backpressure: levels and one-cycle pulses only.
interface game_mode_if;
    import game_pkg::*;

    logic       iKeyUp;
    logic       iKeyDown;
    logic       iKeySelect;
    logic       iKeyBack;
    logic       iGameDone;
    game_mode_t oGameMode;
    logic [1:0] oCursor;
    logic       oModeChanged;
    logic       oGameStart;

    // Board / game-core side: drives the raw keys and the done pulse
    modport master (
        output iKeyUp, iKeyDown, iKeySelect, iKeyBack, iGameDone,
        input  oGameMode, oCursor, oModeChanged, oGameStart
    );

    // Mode controller side
    modport slave (
        input  iKeyUp, iKeyDown, iKeySelect, iKeyBack, iGameDone,
        output oGameMode, oCursor, oModeChanged, oGameStart
    );
endinterface

// File: rtl/game_mode_select_key_debounce.sv
// One push-button conditioner: 2-FF synchroniser, stability counter, press-edge pulse.
// Latency: press pulse on the edge DEBOUNCE_CYCLES+2 edges after the raw fall.
// No backpressure: the press pulse is one cycle wide and is never held.
module key_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic iReset,
    input  logic key_i,     // raw, active-low, asynchronous
    output logic press_o    // one-cycle pulse per accepted press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ;
    logic          settled;

    // The synchronised input has disagreed with the accepted level for long enough
    assign differ  = (sync2_q != level_q);
    assign settled = differ && (cnt_q == CNT_LAST);

    // Next debounce state: count while differing, restart whenever the input agrees
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = settled && level_q;   // only a released->pressed flip is an event
        if (!differ) begin
            cnt_d = '0;
        end else if (settled) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser and debounce registers; reset to the released level
    always_ff @(posedge clk) begin
        if (iReset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/game_mode_select.sv
// Game mode controller: conditions four buttons and runs the menu/enter/play/exit FSM.
// Latency: registered outputs, one edge after a press pulse or iGameDone.
// No backpressure: every output is a level or a one-cycle pulse.
module game_mode_select #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_GAMES       = game_pkg::NUM_GAMES
) (
    input  logic        clk,
    input  logic        iReset,
    game_mode_if.slave  bus
);
    import game_pkg::*;

    localparam int            CW        = $clog2(NUM_GAMES + 1);
    localparam logic [CW-1:0] CUR_FIRST = CW'(1);
    localparam logic [CW-1:0] CUR_LAST  = CW'(NUM_GAMES);

    localparam logic [1:0] S_MENU  = MENU;
    localparam logic [1:0] S_ENTER = ENTER;
    localparam logic [1:0] S_PLAY  = PLAY;
    localparam logic [1:0] S_EXIT  = EXIT;

    logic          up_press, down_press, sel_press, back_press;
    logic [1:0]    state_q, state_d;
    game_mode_t    mode_q, mode_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic          changed_q, changed_d;
    logic          start_q, start_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .clk(clk), .iReset(iReset), .key_i(bus.iKeyUp), .press_o(up_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
        .clk(clk), .iReset(iReset), .key_i(bus.iKeyDown), .press_o(down_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_select (
        .clk(clk), .iReset(iReset), .key_i(bus.iKeySelect), .press_o(sel_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_back (
        .clk(clk), .iReset(iReset), .key_i(bus.iKeyBack), .press_o(back_press)
    );

    // Next state and next outputs; outputs are those of the state being entered
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cursor_d  = cursor_q;
        changed_d = 1'b0;
        start_d   = 1'b0;
        case (state_q)
            S_MENU: begin
                if (sel_press) begin
                    // Select beats a simultaneous Up/Down: the pre-move cursor is used
                    state_d   = S_ENTER;
                    mode_d    = cursor_to_mode(2'(cursor_q));
                    changed_d = 1'b1;
                    start_d   = 1'b1;
                end else if (up_press && !down_press) begin
                    cursor_d = (cursor_q == CUR_FIRST) ? CUR_LAST : cursor_q - CUR_FIRST;
                end else if (down_press && !up_press) begin
                    cursor_d = (cursor_q == CUR_LAST) ? CUR_FIRST : cursor_q + CUR_FIRST;
                end
            end
            S_ENTER: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (back_press || bus.iGameDone) begin
                    state_d   = S_EXIT;
                    mode_d    = MODE_MENU;
                    changed_d = 1'b1;
                end
            end
            S_EXIT: begin
                state_d = S_MENU;
            end
            default: begin
                state_d = S_MENU;
                mode_d  = MODE_MENU;
            end
        endcase
    end

    // State and output registers; reset lands in the menu without a change pulse
    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q   <= S_MENU;
            mode_q    <= MODE_MENU;
            cursor_q  <= CUR_FIRST;
            changed_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cursor_q  <= cursor_d;
            changed_q <= changed_d;
            start_q   <= start_d;
        end
    end

    assign bus.oGameMode    = mode_q;
    assign bus.oCursor      = 2'(cursor_q);
    assign bus.oModeChanged = changed_q;
    assign bus.oGameStart   = start_q;

endmodule

// File: tb/tb_game_mode_select.sv
// Scoreboard bench for game_mode_select with DEBOUNCE_CYCLES=4, NUM_GAMES=2.
// Expected output snapshots are queued with their due cycle and compared at negedge.
// Keys are driven #1 after a posedge; that posedge is the reference cycle of a step.
module tb_game_mode_select;
    import game_pkg::*;

    logic clk = 1'b0;
    logic iReset;
    int   cyc = 0;

    game_mode_if bus ();

    game_mode_select #(
        .DEBOUNCE_CYCLES(4),
        .NUM_GAMES(2)
    ) dut (
        .clk(clk),
        .iReset(iReset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    at;
        string tag;
        int    mode;
        int    cur;
        int    chg;
        int    st;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Queue an expected output snapshot dc cycles after the current cycle
    task automatic expect_at(input string tag, input int dc, input int mode,
                             input int cur, input int chg, input int st);
        exp_t e;
        int   pos;
        e.at   = cyc + dc;
        e.tag  = tag;
        e.mode = mode;
        e.cur  = cur;
        e.chg  = chg;
        e.st   = st;
        pos    = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > e.at) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    // Compare every snapshot that has come due
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                check({e.tag, ".due_cycle"}, cyc, e.at);
            end else begin
                check({e.tag, ".mode"},    bus.oGameMode,    e.mode);
                check({e.tag, ".cursor"},  bus.oCursor,      e.cur);
                check({e.tag, ".changed"}, bus.oModeChanged, e.chg);
                check({e.tag, ".start"},   bus.oGameStart,   e.st);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the selected keys low for 'hold' cycles, then release and let them settle
    task automatic press(input logic up, input logic down, input logic sel,
                         input logic back, input int hold);
        bus.iKeyUp     = ~up;
        bus.iKeyDown   = ~down;
        bus.iKeySelect = ~sel;
        bus.iKeyBack   = ~back;
        tick(hold);
        bus.iKeyUp     = 1'b1;
        bus.iKeyDown   = 1'b1;
        bus.iKeySelect = 1'b1;
        bus.iKeyBack   = 1'b1;
        tick(12);
    endtask

    task automatic pulse_done();
        bus.iGameDone = 1'b1;
        tick(1);
        bus.iGameDone = 1'b0;
        tick(5);
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        iReset        = 1'b1;
        bus.iKeyUp     = 1'b1;
        bus.iKeyDown   = 1'b1;
        bus.iKeySelect = 1'b1;
        bus.iKeyBack   = 1'b1;
        bus.iGameDone  = 1'b0;

        // Reset held for two edges
        expect_at("reset", 2, 0, 1, 0, 0);
        tick(2);
        iReset = 1'b0;
        expect_at("idle", 1, 0, 1, 0, 0);
        tick(3);

        // Three-cycle glitch on Down: no event
        expect_at("glitch_a", 4, 0, 1, 0, 0);
        expect_at("glitch_b", 7, 0, 1, 0, 0);
        expect_at("glitch_c", 10, 0, 1, 0, 0);
        bus.iKeyDown = 1'b0;
        tick(3);
        bus.iKeyDown = 1'b1;
        tick(12);

        // Long Down press: one step, exactly 7 cycles after the fall
        expect_at("dbn_pre",  6,  0, 1, 0, 0);
        expect_at("dbn_step", 7,  0, 2, 0, 0);
        expect_at("dbn_held", 19, 0, 2, 0, 0);
        expect_at("dbn_rel",  28, 0, 2, 0, 0);
        press(0, 1, 0, 0, 20);

        // Wrap-around and Up+Down cancel
        expect_at("wrap_down", 7, 0, 1, 0, 0);
        press(0, 1, 0, 0, 10);
        expect_at("wrap_up", 7, 0, 2, 0, 0);
        press(1, 0, 0, 0, 10);
        expect_at("updown_a", 7, 0, 2, 0, 0);
        expect_at("updown_b", 9, 0, 2, 0, 0);
        press(1, 1, 0, 0, 10);

        // Back to cursor 1, then enter the reaction game
        expect_at("to_cur1", 7, 0, 1, 0, 0);
        press(0, 1, 0, 0, 10);
        expect_at("ent_pre",   6, 0, 1, 0, 0);
        expect_at("ent",       7, 1, 1, 1, 1);
        expect_at("ent_after", 8, 1, 1, 0, 0);
        press(0, 0, 1, 0, 10);

        // Up/Down ignored while playing
        expect_at("play_up_a", 7, 1, 1, 0, 0);
        expect_at("play_up_b", 9, 1, 1, 0, 0);
        press(1, 0, 0, 0, 10);
        expect_at("play_dn_a", 7, 1, 1, 0, 0);
        expect_at("play_dn_b", 9, 1, 1, 0, 0);
        press(0, 1, 0, 0, 10);

        // Back leaves the reaction game
        expect_at("back1",       7, 0, 1, 1, 0);
        expect_at("back1_after", 8, 0, 1, 0, 0);
        press(0, 0, 0, 1, 10);

        // Enter the chimp game, leave on iGameDone
        expect_at("to_cur2", 7, 0, 2, 0, 0);
        press(0, 1, 0, 0, 10);
        expect_at("ent2",       7, 2, 2, 1, 1);
        expect_at("ent2_after", 8, 2, 2, 0, 0);
        press(0, 0, 1, 0, 10);
        expect_at("done_exit",  1, 0, 2, 1, 0);
        expect_at("done_after", 2, 0, 2, 0, 0);
        pulse_done();

        // Enter chimp again, leave on Back
        expect_at("ent3", 7, 2, 2, 1, 1);
        press(0, 0, 1, 0, 10);
        expect_at("back2",       7, 0, 2, 1, 0);
        expect_at("back2_after", 8, 0, 2, 0, 0);
        press(0, 0, 0, 1, 10);

        // iGameDone in the menu is ignored
        expect_at("done_menu_a", 1, 0, 2, 0, 0);
        expect_at("done_menu_b", 3, 0, 2, 0, 0);
        pulse_done();

        // Reset while playing: straight to the menu, no change pulse
        expect_at("ent4", 7, 2, 2, 1, 1);
        press(0, 0, 1, 0, 10);
        iReset = 1'b1;
        expect_at("rst_play_a", 1, 0, 1, 0, 0);
        expect_at("rst_play_b", 2, 0, 1, 0, 0);
        tick(2);
        iReset = 1'b0;
        expect_at("rst_after_a", 1, 0, 1, 0, 0);
        expect_at("rst_after_b", 3, 0, 1, 0, 0);
        tick(5);

        // Select and Down together at cursor 1: Select wins with the old cursor
        expect_at("sel_down",       7, 1, 1, 1, 1);
        expect_at("sel_down_after", 8, 1, 1, 0, 0);
        press(0, 1, 1, 0, 10);

        tick(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
